// File: rtl/rca_word_serial_ctrl.sv
// Word-serial wide adder: one WIDTH-bit ripple-carry slice per clock, LSB first,
// with a registered carry linking slices and valid/ready channels on both sides.

module Nbit_RCA #(
  parameter int N = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

module rca_word_serial_ctrl #(
  parameter int WIDTH  = 10,
  parameter int NSLICE = 4,
  parameter int CNTW   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*NSLICE-1:0]   in_a,
  input  logic [WIDTH*NSLICE-1:0]   in_b,
  input  logic                      in_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*NSLICE-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      busy,
  output logic [CNTW-1:0]           ops_done
);
  localparam int OPW  = WIDTH * NSLICE;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  slice_a, slice_b, slice_s;
  logic              slice_co;

  assign slice_a = a_q[idx_q*WIDTH +: WIDTH];
  assign slice_b = b_q[idx_q*WIDTH +: WIDTH];

  Nbit_RCA #(.N(WIDTH)) u_rca (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*WIDTH +: WIDTH] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NSLICE - 1)) begin
          cout_d  = slice_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears everything, including any in-flight result and the op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign ops_done  = cnt_q;
endmodule

// File: tb/tb_rca_word_serial_ctrl.sv
// Directed bench for rca_word_serial_ctrl (WIDTH=10, NSLICE=4): hand-computed sums,
// latency, backpressure, mid-operation reset and back-to-back issue interval.

module tb_rca_word_serial_ctrl;
  localparam int WIDTH  = 10;
  localparam int NSLICE = 4;
  localparam int CNTW   = 16;
  localparam int OPW    = WIDTH * NSLICE;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_a, in_b;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  out_sum;
  logic            out_cout;
  logic            busy;
  logic [CNTW-1:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  rca_word_serial_ctrl #(.WIDTH(WIDTH), .NSLICE(NSLICE), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Issue one operand pair and wait for the result; checks latency and result.
  task automatic do_op(input string tag, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                       input logic cin, input logic [OPW-1:0] exp_sum, input logic exp_cout);
    int n;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '1;
    in_b     = '1;
    in_cin   = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, n, NSLICE);
    check_eq({tag, "_sum"}, out_sum, exp_sum);
    check_eq({tag, "_cout"}, out_cout, exp_cout);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CNTW-1:0] base;
    logic [OPW-1:0]  all1;
    int k, t1, seen;
    bit got1, acc2;

    rst = 1'b1; in_valid = 1'b1; in_a = 40'd5; in_b = 40'd7; in_cin = 1'b0; out_ready = 1'b0;
    all1 = '1;

    // Reset held three cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_out_sum", out_sum, 0);
      check_eq("rst_out_cout", out_cout, 1'b0);
      check_eq("rst_ops_done", ops_done, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_no_accept_busy", busy, 1'b0);

    // Basic add and full carry chain
    out_ready = 1'b1;
    do_op("basic", 40'd598, 40'd1024, 1'b0, 40'd1622, 1'b0);
    @(negedge clk);
    check_eq("basic_ops_done", ops_done, 1);
    check_eq("basic_out_valid_drop", out_valid, 1'b0);
    do_op("chain_cin", all1, 40'd0, 1'b1, 40'd0, 1'b1);
    do_op("chain_b1", all1, 40'd1, 1'b0, 40'd0, 1'b1);
    @(negedge clk);
    check_eq("chain_ops_done", ops_done, 3);

    // Backpressure in DONE with in_valid pulses
    out_ready = 1'b0;
    do_op("bp", 40'd217, 40'd298, 1'b0, 40'd515, 1'b0);
    base = ops_done;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 40'd2; in_b = 40'd98; in_cin = 1'b0;
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_sum_stable", out_sum, 40'd515);
      check_eq("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ops_inc", ops_done, base + 1'b1);
    check_eq("bp_in_ready_rise", in_ready, 1'b1);
    check_eq("bp_pulse_not_taken", busy, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    in_valid = 1'b1; in_a = 40'd222; in_b = 40'd555; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_ops_done", ops_done, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("mid_rst_no_out_valid", seen, 0);
    do_op("after_rst", 40'd2, 40'd98, 1'b0, 40'd100, 1'b0);

    // Back-to-back with out_ready high
    @(negedge clk);
    base = ops_done;
    check_eq("b2b_in_ready0", in_ready, 1'b1);
    in_valid = 1'b1; in_a = 40'd222; in_b = 40'd555; in_cin = 1'b0;
    @(negedge clk);
    in_a = 40'd2; in_b = 40'd98;
    k = 1; t1 = -1; got1 = 1'b0; acc2 = 1'b0;
    while (k < 40) begin
      if (out_valid && !got1) begin
        got1 = 1'b1;
        check_eq("b2b_sum1", out_sum, 40'd777);
      end
      if (!acc2 && in_ready) begin
        acc2 = 1'b1;
        t1 = k;
        @(negedge clk);
        k++;
        in_valid = 1'b0;
        in_a = '0; in_b = '0;
      end else if (acc2 && out_valid) begin
        break;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check_eq("b2b_interval", t1, 6);
    check_eq("b2b_out_valid2", out_valid, 1'b1);
    check_eq("b2b_sum2", out_sum, 40'd100);
    @(negedge clk);
    check_eq("b2b_ops_done", ops_done, base + 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
